divider_control: RTL and testbench
==================================

Name: divider_control

Overview:
- Sequential 8-bit restoring shift-subtract divider: control FSM plus its own A/Q/D datapath.
- It is the inverse companion of the lab's shift-add multiplier and sits beside it on the same board-level switch/button interface.
- The divisor is loaded from switches, the dividend is captured on Run, and quotient/remainder are presented when Done is high.

Parameters:
- WIDTH, 8, operand/result width. The 8-iteration count is derived from it; the bench only exercises 8.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high; forces IDLE and clears all registers.
- Run  input  1  level-sensitive start; must be held until result is read.
- ClearA_LoadB  input  1  in IDLE, loads Din into divisor register D.
- Din  input  8  switch data: divisor when ClearA_LoadB, dividend on Run.
- Quotient  output  8  Q register.
- Remainder  output  8  A[7:0] register.
- Busy  output  1  high in LOAD/SHIFT/TRYSUB.
- Done  output  1  high in HOLD only.
- DivByZero  output  1  sticky flag; set in LOAD when D==0, cleared on next LOAD or Reset.

Behaviour:
- Reset values: state=IDLE; A (9 bits)=0, Q=0, D=0, iteration counter=0; all outputs 0.
- States: IDLE, LOAD, SHIFT, TRYSUB, HOLD.
- IDLE:
  - ClearA_LoadB=1 loads D<=Din.
  - Run=1 goes to LOAD. Run has priority over ClearA_LoadB, so D is not loaded in that cycle.
- LOAD:
  - Q<=Din, A<=0, count<=0, DivByZero<=0.
  - If D==0: DivByZero<=1, Q<=8'hFF, A<={1'b0,Din}, go to HOLD.
  - Otherwise go to SHIFT.
- SHIFT: {A,Q}<={A[7:0],Q,1'b0} (9-bit A receives Q[7]), then TRYSUB.
- TRYSUB:
  - If A>=D (9-bit unsigned compare, D zero-extended): A<=A-D, Q[0]<=1; else Q[0]<=0.
  - count<=count+1.
  - If count==7 before the increment, go to HOLD; else SHIFT.
- HOLD:
  - Registers frozen; Done=1.
  - Go to IDLE when Run=0. Run still high keeps HOLD, so there is no auto-restart.
- Latency: Run sampled at edge t0 (enter LOAD); 8 SHIFT/TRYSUB pairs follow; HOLD is entered on edge t17, so Done=1 after 17 clocks. A divide-by-zero reaches HOLD on edge t1.
- Busy and Done are decoded combinationally from the state register, never both high.
- Din, ClearA_LoadB and Run changes during Busy are ignored, except that Run low does not abort.
- Reset mid-operation immediately returns to IDLE with all registers and outputs 0; D must be reloaded.
- Quotient/Remainder show working registers during Busy and are valid only while Done=1.
- Remainder is always <D when D!=0 (A[8] is 0 at HOLD).

Optional Feature:
- Macro SIGNED_DIV_EN.
- Defined: operands are two's complement.
  - LOAD stores |Din| in Q and |D| in an internal magnitude register, and latches sign_q=Din[7]^D[7] and sign_r=Din[7].
  - In HOLD entry, Q is negated if sign_q and A is negated if sign_r, giving truncation toward zero.
  - Special case -128/-1: Quotient=8'h80 (wraps), Remainder=0.
  - Divide-by-zero returns Quotient=8'hFF and Remainder=Din unchanged.
  - Adds 1 cycle: a FIXUP state between the last TRYSUB and HOLD, so Done appears after 18 clocks.
- Undefined: purely unsigned; no FIXUP state.

Test Plan:
- Load D=7; Din=100, Run=1 held → Busy 16 cycles after LOAD; Done on cycle 17 with Quotient=14, Remainder=2; Run low → IDLE next cycle, Done=0.
- D=1, Din=255 → Quotient=255, Remainder=0. Also D=255, Din=254 → Quotient=0, Remainder=254.
- D=0, Din=5 → HOLD after 1 clock, DivByZero=1, Quotient=8'hFF, Remainder=5. A following valid run (D=5, Din=25) clears DivByZero and gives Quotient=5, Remainder=0.
- Run held high for 40 cycles after Done → state stays HOLD, outputs stable. Pulsing ClearA_LoadB in HOLD leaves D unchanged.
- Reset asserted asynchronously at iteration 4 → all outputs 0 same cycle, state IDLE; a new run after reloading D computes correctly (200/9 → Quotient=22, Remainder=2).
- SIGNED_DIV_EN:
  - D=7, Din=-100 (8'h9C) → Quotient=8'hF2 (-14), Remainder=8'hFE (-2), Done after 18 clocks.
  - D=-1, Din=-128 → Quotient=8'h80, Remainder=0.

Source files
------------

// File: rtl/divider_control_if.sv
// Switch/button and result bundle shared between the divider and its driver.
interface divider_control_if #(parameter int WIDTH = 8);
  logic             Run;
  logic             ClearA_LoadB;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Busy;
  logic             Done;
  logic             DivByZero;

  modport master (
    output Run, ClearA_LoadB, Din,
    input  Quotient, Remainder, Busy, Done, DivByZero
  );

  modport slave (
    input  Run, ClearA_LoadB, Din,
    output Quotient, Remainder, Busy, Done, DivByZero
  );
endinterface

// File: rtl/divider_control.sv
// Sequential restoring shift-subtract divider: control FSM with A/Q/D datapath.
// Define SIGNED_DIV_EN for two's-complement operands (adds a FIXUP state).
module divider_control #(
  parameter int WIDTH = 8
) (
  input logic              Clk,
  input logic              Reset,
  divider_control_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SHIFT  = 3'd2,
    S_TRYSUB = 3'd3,
    S_FIXUP  = 3'd4,
    S_HOLD   = 3'd5
  } state_t;

  state_t           state_r;
  logic [WIDTH:0]   a_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] d_r;
  logic [CW-1:0]    count_r;
  logic             dbz_r;
  logic [WIDTH-1:0] din_mag_s;
  logic [WIDTH-1:0] d_eff_s;
  logic [WIDTH:0]   d_ext_s;

`ifdef SIGNED_DIV_EN
  logic [WIDTH-1:0] d_mag_r;
  logic             sign_q_r;
  logic             sign_r_r;

  // Operands are divided as magnitudes; signs are restored in FIXUP.
  assign din_mag_s = bus.Din[WIDTH-1] ? (-bus.Din) : bus.Din;
  assign d_eff_s   = d_mag_r;
`else
  assign din_mag_s = bus.Din;
  assign d_eff_s   = d_r;
`endif

  assign d_ext_s       = {1'b0, d_eff_s};
  assign bus.Quotient  = q_r;
  assign bus.Remainder = a_r[WIDTH-1:0];
  assign bus.DivByZero = dbz_r;
  assign bus.Busy      = (state_r == S_LOAD) || (state_r == S_SHIFT) ||
                         (state_r == S_TRYSUB) || (state_r == S_FIXUP);
  assign bus.Done      = (state_r == S_HOLD);

  // Control FSM and datapath registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r  <= S_IDLE;
      a_r      <= '0;
      q_r      <= '0;
      d_r      <= '0;
      count_r  <= '0;
      dbz_r    <= 1'b0;
`ifdef SIGNED_DIV_EN
      d_mag_r  <= '0;
      sign_q_r <= 1'b0;
      sign_r_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          // Run wins over ClearA_LoadB, so D is not loaded on the start cycle.
          if (bus.Run) begin
            state_r <= S_LOAD;
          end else if (bus.ClearA_LoadB) begin
            d_r <= bus.Din;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_LOAD: begin
          count_r  <= '0;
`ifdef SIGNED_DIV_EN
          d_mag_r  <= d_r[WIDTH-1] ? (-d_r) : d_r;
          sign_q_r <= bus.Din[WIDTH-1] ^ d_r[WIDTH-1];
          sign_r_r <= bus.Din[WIDTH-1];
`endif
          if (d_r == '0) begin
            dbz_r   <= 1'b1;
            q_r     <= '1;
            a_r     <= {1'b0, bus.Din};
            state_r <= S_HOLD;
          end else begin
            dbz_r   <= 1'b0;
            q_r     <= din_mag_s;
            a_r     <= '0;
            state_r <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {a_r, q_r} <= {a_r[WIDTH-1:0], q_r, 1'b0};
          state_r    <= S_TRYSUB;
        end
        S_TRYSUB: begin
          if (a_r >= d_ext_s) begin
            a_r    <= a_r - d_ext_s;
            q_r[0] <= 1'b1;
          end else begin
            q_r[0] <= 1'b0;
          end
          count_r <= count_r + CNT_ONE;
          if (count_r == LAST_CNT) begin
`ifdef SIGNED_DIV_EN
            state_r <= S_FIXUP;
`else
            state_r <= S_HOLD;
`endif
          end else begin
            state_r <= S_SHIFT;
          end
        end
        S_FIXUP: begin
`ifdef SIGNED_DIV_EN
          // Truncation toward zero: quotient takes the XOR sign, remainder the dividend sign.
          q_r     <= sign_q_r ? (-q_r) : q_r;
          a_r     <= sign_r_r ? {1'b0, -a_r[WIDTH-1:0]} : a_r;
`endif
          state_r <= S_HOLD;
        end
        S_HOLD: begin
          if (!bus.Run) begin
            state_r <= S_IDLE;
          end else begin
            state_r <= S_HOLD;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_control.sv
// Directed self-checking bench for divider_control (unsigned or SIGNED_DIV_EN build).
module tb_divider_control;

  logic Clk;
  logic Reset;
  int   tests;
  int   fails;

`ifdef SIGNED_DIV_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  divider_control_if #(.WIDTH(8)) ifc ();

  divider_control #(.WIDTH(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (ifc.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_d(input logic [7:0] d);
    ifc.Din = d;
    ifc.ClearA_LoadB = 1'b1;
    tick();
    ifc.ClearA_LoadB = 1'b0;
  endtask

  // Starts a division, waits (bounded) for Done and checks latency and results.
  task automatic run_div(input string tag, input logic [7:0] din, input logic [7:0] eq,
                         input logic [7:0] er, input logic edz, input int elat);
    int cyc;
    int busy_n;
    ifc.Din = din;
    ifc.Run = 1'b1;
    tick();
    cyc = 0;
    busy_n = 0;
    while (!ifc.Done && cyc < 60) begin
      if (ifc.Busy) busy_n++;
      tick();
      cyc++;
    end
    chk({tag, " latency"}, cyc, elat);
    chk({tag, " busy_cycles"}, busy_n, elat);
    chk({tag, " busy_in_hold"}, {31'd0, ifc.Busy}, 32'd0);
    chk({tag, " quotient"}, {24'd0, ifc.Quotient}, {24'd0, eq});
    chk({tag, " remainder"}, {24'd0, ifc.Remainder}, {24'd0, er});
    chk({tag, " divbyzero"}, {31'd0, ifc.DivByZero}, {31'd0, edz});
  endtask

  task automatic release_run(input string tag);
    ifc.Run = 1'b0;
    tick();
    chk({tag, " done_cleared"}, {31'd0, ifc.Done}, 32'd0);
    chk({tag, " idle_not_busy"}, {31'd0, ifc.Busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] q_snap;
    logic [7:0] r_snap;
    tests = 0;
    fails = 0;
    ifc.Run = 1'b0;
    ifc.ClearA_LoadB = 1'b0;
    ifc.Din = 8'd0;
    Reset = 1'b1;
    tick();
    tick();
    chk("reset quotient", {24'd0, ifc.Quotient}, 32'd0);
    chk("reset remainder", {24'd0, ifc.Remainder}, 32'd0);
    chk("reset busy", {31'd0, ifc.Busy}, 32'd0);
    chk("reset done", {31'd0, ifc.Done}, 32'd0);
    chk("reset dbz", {31'd0, ifc.DivByZero}, 32'd0);
    Reset = 1'b0;
    tick();

    // 100 / 7
`ifdef SIGNED_DIV_EN
    load_d(8'd7);
    run_div("s_100_7", 8'd100, 8'd14, 8'd2, 1'b0, LAT);
    release_run("s_100_7");
    run_div("s_m100_7", 8'h9C, 8'hF2, 8'hFE, 1'b0, LAT);
    release_run("s_m100_7");
    load_d(8'hFF);
    run_div("s_m128_m1", 8'h80, 8'h80, 8'h00, 1'b0, LAT);
    release_run("s_m128_m1");
`else
    load_d(8'd7);
    run_div("u_100_7", 8'd100, 8'd14, 8'd2, 1'b0, LAT);
    release_run("u_100_7");
`endif

    // 255 / 1 (also -1 / 1 when signed)
    load_d(8'd1);
    run_div("255_1", 8'd255, 8'hFF, 8'h00, 1'b0, LAT);
    release_run("255_1");

    // 254 / 255 (-2 / -1 when signed)
    load_d(8'd255);
`ifdef SIGNED_DIV_EN
    run_div("254_255", 8'd254, 8'd2, 8'd0, 1'b0, LAT);
`else
    run_div("254_255", 8'd254, 8'd0, 8'd254, 1'b0, LAT);
`endif
    release_run("254_255");

    // divide by zero, then a valid run clears the flag
    load_d(8'd0);
    run_div("dz_5_0", 8'd5, 8'hFF, 8'd5, 1'b1, 1);
    release_run("dz_5_0");
    load_d(8'd5);
    run_div("25_5", 8'd25, 8'd5, 8'd0, 1'b0, LAT);

    // Run held high in HOLD: outputs stable, ClearA_LoadB ignored
    q_snap = 8'd5;
    r_snap = 8'd0;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) begin
        ifc.Din = 8'd3;
        ifc.ClearA_LoadB = 1'b1;
      end else begin
        ifc.ClearA_LoadB = 1'b0;
      end
      tick();
      chk("hold done", {31'd0, ifc.Done}, 32'd1);
      chk("hold quotient", {24'd0, ifc.Quotient}, {24'd0, q_snap});
      chk("hold remainder", {24'd0, ifc.Remainder}, {24'd0, r_snap});
    end
    release_run("hold");
    run_div("d_kept", 8'd40, 8'd8, 8'd0, 1'b0, LAT);
    release_run("d_kept");

    // asynchronous reset mid-operation
    load_d(8'd7);
    ifc.Din = 8'd100;
    ifc.Run = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    chk("mid busy", {31'd0, ifc.Busy}, 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk("async quotient", {24'd0, ifc.Quotient}, 32'd0);
    chk("async remainder", {24'd0, ifc.Remainder}, 32'd0);
    chk("async busy", {31'd0, ifc.Busy}, 32'd0);
    chk("async done", {31'd0, ifc.Done}, 32'd0);
    ifc.Run = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    run_div("d_cleared", 8'd5, 8'hFF, 8'd5, 1'b1, 1);
    release_run("d_cleared");
    load_d(8'd9);
`ifdef SIGNED_DIV_EN
    run_div("200_9", 8'd200, 8'hFA, 8'hFE, 1'b0, LAT);
`else
    run_div("200_9", 8'd200, 8'd22, 8'd2, 1'b0, LAT);
`endif
    release_run("200_9");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
